// File: rtl/serial_adder.sv
// Bit-serial adder: shifts operands LSB-first through an external full-adder stage.
// Optional two's-complement overflow output is enabled with `define SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_x,
   output logic             fa_y,
   output logic             fa_ci,
   input  logic             fa_s,
   input  logic             fa_co,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   // Full-adder operands come straight from registers, never from input ports.
   assign fa_x  = a_sr[0];
   assign fa_y  = b_sr[0];
   assign fa_ci = carry;

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values, exactly as the hardware flops will.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
               carry  <= fa_co;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // The MSB sum bit is still on fa_s, so assemble the final word here.
                  sum   <= {fa_s, sum_sr[WIDTH-1:1]};
                  cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf   <= carry ^ fa_co;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
